// File: rtl/diagnosis_pc_range_monitor_pkg.sv
// Shared widths, config-word layout helper and match-mode encoding for the PC range monitor.
package diagnosis_pc_range_monitor_pkg;

  localparam int DIAGNOSIS_EV_ID_WIDTH     = 8;
  localparam int DIAGNOSIS_TIMESTAMP_WIDTH = 32;

  typedef enum logic {
    MODE_EXACT = 1'b0,
    MODE_RANGE = 1'b1
  } match_mode_e;

  // Per-channel config word, LSB up: lo, hi, ev_id, div, mode, en
  function automatic int conf_width(input int pc_w, input int id_w, input int div_w);
    return 2 * pc_w + id_w + div_w + 2;
  endfunction

endpackage

// File: rtl/diagnosis_event_fifo.sv
// Show-ahead synchronous FIFO: head is visible whenever not empty; a pop frees a slot for a same-cycle push.
module diagnosis_event_fifo #(
  parameter int WIDTH = 41,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             do_push;
  logic             do_pop;

  assign empty     = (wr_ptr_reg == rd_ptr_reg);
  assign full      = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign do_pop    = pop & ~empty;
  assign do_push   = push & (~full | do_pop);
  assign head_data = mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
    end
  end

  // Storage carries no reset; pointer reset alone flushes the queue.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/diagnosis_pc_range_monitor.sv
// Multi-channel retired-PC monitor: exact/range compare, per-channel hit divider,
// priority winner, timestamped event FIFO and saturating drop statistics.
module diagnosis_pc_range_monitor
  import diagnosis_pc_range_monitor_pkg::*;
#(
  parameter int NUM_CHANNELS   = 8,
  parameter int PC_WIDTH       = 32,
  parameter int EV_ID_WIDTH    = DIAGNOSIS_EV_ID_WIDTH,
  parameter int TS_WIDTH       = DIAGNOSIS_TIMESTAMP_WIDTH,
  parameter int DIV_WIDTH      = 8,
  parameter int FIFO_DEPTH     = 4,
  parameter int DROP_CNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      diag_sys_enabled,
  input  logic [NUM_CHANNELS*conf_width(PC_WIDTH, EV_ID_WIDTH, DIV_WIDTH)-1:0] conf_flat_in,
  input  logic                      clr_stat,
  input  logic [PC_WIDTH-1:0]       pc_val,
  input  logic                      pc_enable,
  input  logic [TS_WIDTH-1:0]       time_global,
  output logic                      ev_valid,
  input  logic                      ev_ready,
  output logic [EV_ID_WIDTH-1:0]    ev_id,
  output logic [TS_WIDTH-1:0]       ev_time,
  output logic                      ev_multi,
  output logic                      overflow,
  output logic [DROP_CNT_WIDTH-1:0] drop_count
);

  localparam int CONF_W        = conf_width(PC_WIDTH, EV_ID_WIDTH, DIV_WIDTH);
  localparam int CONF_LO_LSB   = 0;
  localparam int CONF_HI_LSB   = PC_WIDTH;
  localparam int CONF_ID_LSB   = 2 * PC_WIDTH;
  localparam int CONF_DIV_LSB  = CONF_ID_LSB + EV_ID_WIDTH;
  localparam int CONF_MODE_BIT = CONF_DIV_LSB + DIV_WIDTH;
  localparam int CONF_EN_BIT   = CONF_MODE_BIT + 1;
  localparam int EV_W          = EV_ID_WIDTH + TS_WIDTH + 1;

  logic                      s1_valid_reg;
  logic [PC_WIDTH-1:0]       s1_pc_reg;
  logic [TS_WIDTH-1:0]       s1_ts_reg;
  logic [NUM_CHANNELS-1:0]   fire;
  logic [EV_ID_WIDTH-1:0]    ch_id [NUM_CHANNELS];
  logic [EV_ID_WIDTH-1:0]    win_id;
  logic                      win_multi;
  logic                      push;
  logic                      pop;
  logic                      drop;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [EV_W-1:0]           head_data;
  logic                      overflow_reg;
  logic [DROP_CNT_WIDTH-1:0] drop_count_reg;

  // S1: capture the retired PC and its timestamp
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_reg <= 1'b0;
      s1_pc_reg    <= '0;
      s1_ts_reg    <= '0;
    end else begin
      s1_valid_reg <= pc_enable & diag_sys_enabled;
      if (pc_enable & diag_sys_enabled) begin
        s1_pc_reg <= pc_val;
        s1_ts_reg <= time_global;
      end
    end
  end

  // S2: per-channel compare and hit divider
  generate
    for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_ch
      logic [PC_WIDTH-1:0]  lo;
      logic [PC_WIDTH-1:0]  hi;
      logic [DIV_WIDTH-1:0] div;
      match_mode_e          mode;
      logic                 en;
      logic                 match;
      logic                 hit;
      logic [DIV_WIDTH-1:0] cnt_reg;
      logic [DIV_WIDTH:0]   cnt_inc;

      assign lo       = conf_flat_in[gi*CONF_W + CONF_LO_LSB +: PC_WIDTH];
      assign hi       = conf_flat_in[gi*CONF_W + CONF_HI_LSB +: PC_WIDTH];
      assign ch_id[gi] = conf_flat_in[gi*CONF_W + CONF_ID_LSB +: EV_ID_WIDTH];
      assign div      = conf_flat_in[gi*CONF_W + CONF_DIV_LSB +: DIV_WIDTH];
      assign mode     = match_mode_e'(conf_flat_in[gi*CONF_W + CONF_MODE_BIT]);
      assign en       = conf_flat_in[gi*CONF_W + CONF_EN_BIT];

      // An inverted range (lo > hi) can never satisfy both bounds.
      assign match    = (mode == MODE_RANGE) ? ((s1_pc_reg >= lo) && (s1_pc_reg <= hi))
                                             : (s1_pc_reg == lo);
      assign hit      = s1_valid_reg & en & match;
      assign cnt_inc  = {1'b0, cnt_reg} + (DIV_WIDTH+1)'(1);
      assign fire[gi] = hit & (cnt_inc >= {1'b0, div});

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          cnt_reg <= '0;
        end else if (hit) begin
          cnt_reg <= fire[gi] ? '0 : cnt_inc[DIV_WIDTH-1:0];
        end
      end
    end
  endgenerate

  // Lowest index wins: scan downward so the last assignment is the winner.
  always_comb begin
    win_id = '0;
    for (int c = NUM_CHANNELS - 1; c >= 0; c--) begin
      if (fire[c]) win_id = ch_id[c];
    end
    win_multi = ((fire & (fire - NUM_CHANNELS'(1))) != '0);
  end

  assign push = |fire;
  assign pop  = ev_valid & ev_ready;
  assign drop = push & fifo_full & ~pop;

  diagnosis_event_fifo #(
    .WIDTH (EV_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({win_multi, s1_ts_reg, win_id}),
    .pop       (pop),
    .head_data (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign ev_valid = ~fifo_empty;
  assign ev_id    = ev_valid ? head_data[EV_ID_WIDTH-1:0] : '0;
  assign ev_time  = ev_valid ? head_data[EV_ID_WIDTH +: TS_WIDTH] : '0;
  assign ev_multi = ev_valid & head_data[EV_W-1];

  // A clear in the same cycle as a drop suppresses that drop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_reg   <= 1'b0;
      drop_count_reg <= '0;
    end else if (clr_stat) begin
      overflow_reg   <= 1'b0;
      drop_count_reg <= '0;
    end else if (drop) begin
      overflow_reg <= 1'b1;
      if (drop_count_reg != '1) drop_count_reg <= drop_count_reg + DROP_CNT_WIDTH'(1);
    end
  end

  assign overflow   = overflow_reg;
  assign drop_count = drop_count_reg;

endmodule
